// File: rtl/mem_access_ctrl.sv
// Memory stage controller: takes EX/MEM fields, runs a req/ack access to a variable-latency
// data memory, stalls the pipeline until it completes, and feeds the MEM/WB register.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        wb_i,
  input  logic [1:0]        m_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [4:0]        reg_rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [1:0]        wb_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [4:0]        reg_rd_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic              err_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              op, illegal, misaligned, bad, timeout_hit;

  assign op          = m_i[1] ^ m_i[0];
  assign illegal     = &m_i;
  assign misaligned  = op && (alu_result_i[1:0] != 2'b00);
  assign bad         = illegal || misaligned;
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  assign alu_result_o = alu_result_i;
  assign reg_rd_o     = reg_rd_i;

  // Stall is forced low while reset is held, even if a valid op sits on the inputs.
  always_comb begin
    stall_o = 1'b0;
    if (rst_i) begin
      unique case (state_q)
        StIdle:  stall_o = op && !misaligned;
        StBusy:  stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    wb_o = wb_i;
    if (stall_o || (state_q == StIdle && bad)) wb_o = 2'b00;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      read_data_o <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bad) begin
            err_o <= 1'b1;
          end else if (op) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= m_i[0];
            mem_addr_o  <= alu_result_i;
            mem_wdata_o <= write_data_i;
            cnt_q       <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + CntW'(1);
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack_i) begin
            if (!mem_we_o) read_data_o <= mem_rdata_i;
            mem_req_o <= 1'b0;
            state_q   <= StDone;
          end else if (timeout_hit) begin
            if (!mem_we_o) read_data_o <= '0;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed plan steps plus random accesses against a transaction model.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  wb_i, m_i, wb_o;
  logic [31:0] alu_result_i, write_data_i, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] alu_result_o, read_data_o;
  logic [4:0]  reg_rd_i, reg_rd_o;
  logic        mem_req_o, mem_we_o, mem_ack_i, stall_o, err_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd_exp = '0;

  mem_access_ctrl #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wb_i         (wb_i),
    .m_i          (m_i),
    .alu_result_i (alu_result_i),
    .write_data_i (write_data_i),
    .reg_rd_i     (reg_rd_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .stall_o      (stall_o),
    .wb_o         (wb_o),
    .alu_result_o (alu_result_o),
    .reg_rd_o     (reg_rd_o),
    .read_data_o  (read_data_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One instruction through the memory stage; ack_at = BUSY cycle of the ack, 0 = never.
  task automatic access(input logic [1:0] m, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] wb, input int ack_at, input logic [31:0] ack_data);
    bit          is_mem, bad, to;
    int          n_busy;
    logic [4:0]  rd;
    is_mem = (m == 2'b01) || (m == 2'b10);
    bad    = (m == 2'b11) || (is_mem && addr[1:0] != 2'b00);
    rd     = 5'($urandom);
    @(posedge clk_i); #1;
    m_i = m; alu_result_i = addr; write_data_i = wd; wb_i = wb; reg_rd_i = rd; mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("alu_pass", alu_result_o, addr);
    chk("rd_pass", 32'(reg_rd_o), 32'(rd));
    chk("req_idle", 32'(mem_req_o), 0);
    if (bad) begin
      chk("stall_bad", 32'(stall_o), 0);
      chk("wb_bad", 32'(wb_o), 0);
      @(posedge clk_i); #1; m_i = 2'b00;
      @(negedge clk_i);
      chk("err_bad", 32'(err_o), 1);
      chk("req_bad", 32'(mem_req_o), 0);
      chk("rdata_bad", read_data_o, rd_exp);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("err_pulse", 32'(err_o), 0);
      return;
    end
    if (!is_mem) begin
      chk("stall_nop", 32'(stall_o), 0);
      chk("wb_nop", 32'(wb_o), 32'(wb));
      return;
    end
    chk("stall_start", 32'(stall_o), 1);
    chk("wb_start", 32'(wb_o), 0);
    to     = !(ack_at >= 1 && ack_at <= int'(TO));
    n_busy = to ? int'(TO) : ack_at;
    for (int k = 1; k <= n_busy; k++) begin
      @(posedge clk_i); #1;
      mem_ack_i   = (k == ack_at);
      mem_rdata_i = (k == ack_at) ? ack_data : $urandom;
      @(negedge clk_i);
      chk("req_busy", 32'(mem_req_o), 1);
      chk("we_busy", 32'(mem_we_o), 32'(m[0]));
      chk("addr_busy", mem_addr_o, addr);
      if (m[0]) chk("wdata_busy", mem_wdata_o, wd);
      chk("stall_busy", 32'(stall_o), 1);
      chk("wb_busy", 32'(wb_o), 0);
      chk("err_busy", 32'(err_o), 0);
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    if (m == 2'b10) rd_exp = to ? 32'h0 : ack_data;
    @(negedge clk_i);
    chk("stall_done", 32'(stall_o), 0);
    chk("req_done", 32'(mem_req_o), 0);
    chk("wb_done", 32'(wb_o), 32'(wb));
    chk("err_done", 32'(err_o), 32'(to));
    chk("rdata_done", read_data_o, rd_exp);
    @(posedge clk_i); #1; m_i = 2'b00;
    @(negedge clk_i);
    chk("err_after", 32'(err_o), 0);
    chk("stall_after", 32'(stall_o), 0);
    chk("req_after", 32'(mem_req_o), 0);
    chk("rdata_after", read_data_o, rd_exp);
  endtask

  initial begin
    rst_i = 1'b0; wb_i = 2'b00; m_i = 2'b10; alu_result_i = 32'h40; write_data_i = '0;
    reg_rd_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata", read_data_o, 0);
    chk("rst_err", 32'(err_o), 0);
    m_i = 2'b00;
    rst_i = 1'b1;

    // Directed plan: load, store, misaligned, illegal, timeout, ack on the last BUSY cycle.
    access(2'b10, 32'h40, 32'h0, 2'b11, 3, 32'hDEADBEEF);
    access(2'b01, 32'h10, 32'h12345678, 2'b10, 1, 32'hCAFEF00D);
    access(2'b10, 32'h42, 32'h0, 2'b01, 1, 32'h1);
    access(2'b11, 32'h40, 32'h0, 2'b11, 1, 32'h1);
    access(2'b10, 32'h80, 32'h0, 2'b01, 0, 32'h0);
    access(2'b10, 32'h84, 32'h0, 2'b10, int'(TO), 32'hA5A5_1234);

    for (int i = 0; i < 10; i++) begin
      access(2'b00, $urandom, $urandom, 2'($urandom), 0, 32'h0);
    end

    // Reset in the second BUSY cycle of a load.
    @(posedge clk_i); #1;
    m_i = 2'b10; alu_result_i = 32'h100; wb_i = 2'b11;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; rd_exp = '0;
    #1;
    chk("midrst_req", 32'(mem_req_o), 0);
    chk("midrst_stall", 32'(stall_o), 0);
    chk("midrst_addr", mem_addr_o, 0);
    chk("midrst_rdata", read_data_o, 0);
    chk("midrst_err", 32'(err_o), 0);
    @(negedge clk_i);
    m_i = 2'b00; rst_i = 1'b1;
    access(2'b10, 32'h200, 32'h0, 2'b01, 2, 32'h0BADC0DE);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      access(2'($urandom_range(0, 3)), a, $urandom, 2'($urandom), $urandom_range(0, 5), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
